// File: rtl/mac_array_acc.sv
// mac_array_acc: ARRAY_ROWS x ARRAY_COLS multiply-accumulate array.
// A job starts with a one-cycle start_i pulse in IDLE and then accumulates
// len_i operand beats. Each beat adds one signed dot product per row. When the
// last beat has been accepted, the row results are held until out_ready_i.
// Optional feature: define MAC_ARRAY_ACC_SAT_EN to saturate each row result
// to the signed DATA_WIDTH range. Without the macro, each row result is the
// low DATA_WIDTH bits of its accumulator.
module mac_array_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_ROWS = 8,
  parameter int ARRAY_COLS = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start_i,
  input  logic [15:0]                              len_i,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  input  logic [DATA_WIDTH*ARRAY_COLS-1:0]         data_a_i,
  input  logic [DATA_WIDTH*ARRAY_ROWS*ARRAY_COLS-1:0] weight_i,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [DATA_WIDTH*ARRAY_ROWS-1:0]         mac_result_o,
  output logic                                     busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [15:0]                 r_cnt;
  logic signed [ACC_WIDTH-1:0] r_acc [ARRAY_ROWS];
  logic signed [ACC_WIDTH-1:0] w_dot [ARRAY_ROWS];
  logic                        w_xfer;
  logic                        w_last;

`ifdef MAC_ARRAY_ACC_SAT_EN
  // Clamp the accumulator to the signed DATA_WIDTH range. The value fits when
  // every bit from the DATA_WIDTH-1 position upwards matches the sign bit.
  function automatic logic [DATA_WIDTH-1:0] f_row(input logic signed [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-DATA_WIDTH:0] v_hi;
    v_hi = v[ACC_WIDTH-1:DATA_WIDTH-1];
    if ((v_hi == '0) || (v_hi == '1))
      f_row = v[DATA_WIDTH-1:0];
    else if (v[ACC_WIDTH-1])
      f_row = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      f_row = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  endfunction
`else
  // Plain truncation. The caller passes only the bits that are kept.
  function automatic logic [DATA_WIDTH-1:0] f_row(input logic [DATA_WIDTH-1:0] v);
    f_row = v;
  endfunction

  // The upper accumulator bits do not reach any output in this build.
  logic w_unused_hi;
  always_comb begin
    w_unused_hi = 1'b0;
    for (int r = 0; r < ARRAY_ROWS; r++)
      w_unused_hi = w_unused_hi ^ (^r_acc[r][ACC_WIDTH-1:DATA_WIDTH]);
  end
`endif

  assign w_xfer = (r_state == ACCUM) && in_valid_i;
  assign w_last = w_xfer && (r_cnt == 16'd1);

  // Per-row signed dot product of the current beat. Products are formed at
  // full 2*DATA_WIDTH precision and sign-extended into the accumulator width.
  always_comb begin
    logic signed [2*DATA_WIDTH-1:0] v_a;
    logic signed [2*DATA_WIDTH-1:0] v_w;
    logic signed [2*DATA_WIDTH-1:0] v_prod;
    logic signed [ACC_WIDTH-1:0]    v_sum;
    v_a    = '0;
    v_w    = '0;
    v_prod = '0;
    for (int r = 0; r < ARRAY_ROWS; r++) begin
      v_sum = '0;
      for (int c = 0; c < ARRAY_COLS; c++) begin
        v_a    = (2*DATA_WIDTH)'($signed(data_a_i[c*DATA_WIDTH +: DATA_WIDTH]));
        v_w    = (2*DATA_WIDTH)'($signed(weight_i[(r*ARRAY_COLS+c)*DATA_WIDTH +: DATA_WIDTH]));
        v_prod = v_a * v_w;
        v_sum  = v_sum + ACC_WIDTH'(v_prod);
      end
      w_dot[r] = v_sum;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next-state logic and handshake outputs decoded from the current state.
  always_comb begin
    w_next      = r_state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i)
          w_next = ACCUM;
      end
      ACCUM: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (w_last)
          w_next = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
        if (out_ready_i)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Beat counter and accumulators. Both are cleared on job start, and both
  // advance only on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int r = 0; r < ARRAY_ROWS; r++)
        r_acc[r] <= '0;
    end else if ((r_state == IDLE) && start_i) begin
      r_cnt <= (len_i == 16'd0) ? 16'd1 : len_i;
      for (int r = 0; r < ARRAY_ROWS; r++)
        r_acc[r] <= '0;
    end else if (w_xfer) begin
      r_cnt <= r_cnt - 16'd1;
      for (int r = 0; r < ARRAY_ROWS; r++)
        r_acc[r] <= r_acc[r] + w_dot[r];
    end
  end

  // Row results are driven only while a result is being offered, otherwise zero.
  always_comb begin
    mac_result_o = '0;
    if (r_state == DONE) begin
      for (int r = 0; r < ARRAY_ROWS; r++) begin
`ifdef MAC_ARRAY_ACC_SAT_EN
        mac_result_o[r*DATA_WIDTH +: DATA_WIDTH] = f_row(r_acc[r]);
`else
        mac_result_o[r*DATA_WIDTH +: DATA_WIDTH] = f_row(r_acc[r][DATA_WIDTH-1:0]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_mac_array_acc.sv
// Testbench for mac_array_acc (DATA_WIDTH=8, 2x2 array). Expected row
// results are queued when a job is issued. A monitor compares them against
// each accepted output.
module tb_mac_array_acc;
  localparam int DW = 8;
  localparam int R  = 2;
  localparam int C  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic [15:0]       len_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DW*C-1:0]   data_a_i;
  logic [DW*R*C-1:0] weight_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DW*R-1:0]   mac_result_o;
  logic              busy_o;

  int errors = 0;
  int checks = 0;
  logic [DW*R-1:0] exp_q[$];

  always #5 clk = ~clk;

  mac_array_acc #(
    .DATA_WIDTH(DW),
    .ARRAY_ROWS(R),
    .ARRAY_COLS(C)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .len_i        (len_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .data_a_i     (data_a_i),
    .weight_i     (weight_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .mac_result_o (mac_result_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Compare each accepted result against the next queued expectation.
  always @(negedge clk) begin
    logic [DW*R-1:0] e;
    if (rst_n && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%0h required none", mac_result_o);
      end else begin
        e = exp_q.pop_front();
        check("result", {16'h0, mac_result_o}, {16'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] w00, input logic [7:0] w01,
                          input logic [7:0] w10, input logic [7:0] w11);
    data_a_i = {a1, a0};
    weight_i = {w11, w10, w01, w00};
  endtask

  task automatic start_job(input logic [15:0] len);
    start_i = 1'b1;
    len_i   = len;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send(input int n);
    int sent;
    int g;
    sent = 0;
    g = 0;
    in_valid_i = 1'b1;
    while (sent < n && g < 50) begin
      if (in_ready_o) sent++;
      tick();
      g++;
    end
    in_valid_i = 1'b0;
    check("beats_accepted", sent, n);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy_o && g < 50) begin
      tick();
      g++;
    end
    check("return_idle", {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int cnt;
    rst_n       = 1'b1;
    start_i     = 1'b0;
    len_i       = '0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    data_a_i    = '0;
    weight_i    = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  {31'h0, in_ready_o},  32'h0);
    check("rst_out_valid", {31'h0, out_valid_o}, 32'h0);
    check("rst_busy",      {31'h0, busy_o},      32'h0);
    check("rst_result",    {16'h0, mac_result_o}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single-beat job started on the first edge after reset release.
    set_beat(8'd2, 8'd3, 8'd1, 8'd1, 8'd4, 8'hFF);
    start_job(16'd1);
    check("start_after_reset", {31'h0, busy_o}, 32'h1);
    exp_q.push_back({8'd5, 8'd5});
    send(1);
    check("latency_out_valid", {31'h0, out_valid_o}, 32'h1);
    wait_idle();

    // Three beats with in_valid_i toggling. Idle cycles must not accumulate.
    start_job(16'd3);
    exp_q.push_back({8'd15, 8'd15});
    for (int i = 0; i < 5; i++) begin
      in_valid_i = (i % 2 == 0);
      tick();
    end
    in_valid_i = 1'b0;
    check("toggle_done", {31'h0, out_valid_o}, 32'h1);
    wait_idle();

    // Large accumulator: 127*127*2 = 32258 = 0x7E02.
    set_beat(8'd127, 8'd127, 8'd127, 8'd127, 8'd0, 8'd0);
`ifdef MAC_ARRAY_ACC_SAT_EN
    exp_q.push_back({8'h00, 8'h7F});
`else
    exp_q.push_back({8'h00, 8'h02});
`endif
    start_job(16'd1);
    send(1);
    wait_idle();

    // Back-pressure in DONE: output held, no input accepted, start ignored.
    set_beat(8'd2, 8'd3, 8'd1, 8'd1, 8'd4, 8'hFF);
    start_job(16'd1);
    out_ready_i = 1'b0;
    exp_q.push_back({8'd5, 8'd5});
    send(1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",    {31'h0, out_valid_o},  32'h1);
      check("hold_result",   {16'h0, mac_result_o}, 32'h0505);
      check("hold_in_ready", {31'h0, in_ready_o},   32'h0);
      start_i = (i == 2);
      tick();
    end
    start_i     = 1'b1;
    out_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("start_at_ack_ignored", {31'h0, busy_o},      32'h0);
    check("valid_drop_after_ack", {31'h0, out_valid_o}, 32'h0);

    // Reset in the middle of a four-beat job.
    start_job(16'd4);
    send(2);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  {31'h0, in_ready_o},   32'h0);
    check("midrst_busy",      {31'h0, busy_o},       32'h0);
    check("midrst_out_valid", {31'h0, out_valid_o},  32'h0);
    check("midrst_result",    {16'h0, mac_result_o}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_valid_o || busy_o) seen++;
      tick();
    end
    check("no_partial_result", seen, 0);
    start_job(16'd1);
    exp_q.push_back({8'd5, 8'd5});
    send(1);
    wait_idle();

    // A length of zero is treated as one beat.
    start_job(16'd0);
    exp_q.push_back({8'd5, 8'd5});
    in_valid_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (in_valid_i && in_ready_o) cnt++;
      tick();
    end
    in_valid_i = 1'b0;
    check("len0_beats", cnt, 1);
    wait_idle();

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
